// File: rtl/riscv_mdu.sv
// riscv_mdu -- iterative RISC-V M-extension multiply/divide unit.
//
// Multiplies with a radix-2^BITS_PER_CYCLE shift-add loop. Divides with a
// restoring loop that resolves BITS_PER_CYCLE quotient bits per cycle. Signed
// operations work on operand magnitudes. The sign of the result is applied in
// the same edge that leaves BUSY, so the result is ready N+1 cycles after
// accept, where N = XLEN/BITS_PER_CYCLE. Divide-by-zero and signed overflow
// do not iterate: they produce their result at the edge that accepts them.
//
// Ports
//   clk         clock, rising edge
//   rstn        asynchronous active-low reset
//   flush       kills any operation in progress (priority over all else)
//   wb_stall    downstream stall; holds a completed result in DONE
//   id_bubble   1 = ID slot empty
//   id_mdu_op   1 = ID instruction is an M-extension op
//   id_func     funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   opA, opB    rs1 / rs2 operands
//   mdu_r       registered result, valid while mdu_bubble = 0
//   mdu_bubble  0 only in DONE
//   mdu_stall   requests a hold of the ID/EX pipeline
module riscv_mdu #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            flush,
  input  logic            wb_stall,
  input  logic            id_bubble,
  input  logic            id_mdu_op,
  input  logic [2:0]      id_func,
  input  logic [XLEN-1:0] opA,
  input  logic [XLEN-1:0] opB,
  output logic [XLEN-1:0] mdu_r,
  output logic            mdu_bubble,
  output logic            mdu_stall
);

  localparam int BPC = BITS_PER_CYCLE;
  localparam int N   = XLEN / BPC;
  localparam int CW  = $clog2(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt;
  logic            last;
  logic            accept;

  // ID-side decode
  logic                   is_div_id;
  logic                   a_sgn_id, b_sgn_id;
  logic                   a_neg_id, b_neg_id;
  logic signed [XLEN-1:0] opa_s, opb_s;
  logic [XLEN-1:0]        a_mag_id, b_mag_id;
  logic                   div_zero_id, div_ovf_id, quick_id;
  logic [XLEN-1:0]        quick_res_id;

  // Latched operation and iteration registers
  logic [2:0]             func_p1;
  logic                   neg_p1;
  logic [XLEN-1:0]        mcand_p1;
  logic [XLEN-1:0]        acc_hi_p1, acc_lo_p1;
  logic [2*XLEN-1:0]      step_acc;

  // Two's-complement magnitude of a value that is known to be negative when
  // neg is set. The most negative number maps onto itself, which is the
  // correct unsigned magnitude.
  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v,
                                                input logic            neg);
    return neg ? -v : v;
  endfunction

  // One shift-add iteration. hi holds the partial product, lo the remaining
  // multiplier bits; the product leaves the low end of lo as it fills hi.
  function automatic logic [2*XLEN-1:0] mul_step(input logic [XLEN-1:0] hi,
                                                 input logic [XLEN-1:0] lo,
                                                 input logic [XLEN-1:0] mcand);
    logic [XLEN+BPC-1:0]   pp;
    logic [XLEN+BPC-1:0]   sum;
    logic [2*XLEN+BPC-1:0] wide;
    pp   = {{BPC{1'b0}}, mcand} * {{XLEN{1'b0}}, lo[BPC-1:0]};
    sum  = {{BPC{1'b0}}, hi} + pp;
    wide = {sum, lo};
    return wide[2*XLEN+BPC-1:BPC];
  endfunction

  // BPC restoring-division steps. rem is the partial remainder, quo starts as
  // the dividend and collects quotient bits at its low end.
  function automatic logic [2*XLEN-1:0] div_step(input logic [XLEN-1:0] rem_in,
                                                 input logic [XLEN-1:0] quo_in,
                                                 input logic [XLEN-1:0] dvsr);
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] quo;
    logic [XLEN:0]   trial;
    rem = rem_in;
    quo = quo_in;
    for (int i = 0; i < BPC; i++) begin
      trial = {rem, quo[XLEN-1]};
      quo   = {quo[XLEN-2:0], 1'b0};
      if (trial >= {1'b0, dvsr}) begin
        trial  = trial - {1'b0, dvsr};
        quo[0] = 1'b1;
      end
      rem = trial[XLEN-1:0];
    end
    return {rem, quo};
  endfunction

  // Select the architectural result and apply the sign correction.
  // Division: hi = remainder, lo = quotient. Multiply: full 2*XLEN product.
  function automatic logic [XLEN-1:0] finish_res(input logic [2:0]        func,
                                                 input logic              neg,
                                                 input logic [2*XLEN-1:0] acc);
    logic [XLEN-1:0]   sel;
    logic [2*XLEN-1:0] prod;
    if (func[2]) begin
      sel = func[1] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
      return neg ? -sel : sel;
    end
    prod = neg ? -acc : acc;
    return (func[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  endfunction

  // ---- ID decode (combinational, ahead of the accept edge) ----
  assign is_div_id = id_func[2];
  // MUL/MULH/MULHSU treat rs1 as signed; MUL/MULH treat rs2 as signed.
  assign a_sgn_id  = is_div_id ? ~id_func[0] : (id_func[1:0] != 2'b11);
  assign b_sgn_id  = is_div_id ? ~id_func[0] : ~id_func[1];
  assign opa_s     = opA;
  assign opb_s     = opB;
  assign a_neg_id  = a_sgn_id & (opa_s < 0);
  assign b_neg_id  = b_sgn_id & (opb_s < 0);
  assign a_mag_id  = magnitude(opA, a_neg_id);
  assign b_mag_id  = magnitude(opB, b_neg_id);

  assign div_zero_id = is_div_id & (opB == '0);
  assign div_ovf_id  = is_div_id & ~id_func[0] &
                       (opA == {1'b1, {(XLEN-1){1'b0}}}) & (&opB);
  assign quick_id    = div_zero_id | div_ovf_id;
  // id_func[1] distinguishes REM* from DIV*.
  assign quick_res_id = div_zero_id ? (id_func[1] ? opA : {XLEN{1'b1}})
                                    : (id_func[1] ? '0  : opA);

  assign accept = rstn & (state == IDLE) & id_mdu_op & ~id_bubble & ~flush;
  assign last   = (cnt == CW'(N-1));

  always_comb begin
    state_n    = state;
    mdu_stall  = 1'b0;
    mdu_bubble = 1'b1;
    if (flush) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept)    state_n = quick_id ? DONE : BUSY;
        BUSY:    if (last)      state_n = DONE;
        DONE:    if (!wb_stall) state_n = IDLE;
        default:                state_n = IDLE;
      endcase
    end
    mdu_stall  = ((state == BUSY) | accept) & ~flush;
    mdu_bubble = (state != DONE);
  end

  always_comb begin
    step_acc = func_p1[2] ? div_step(acc_hi_p1, acc_lo_p1, mcand_p1)
                          : mul_step(acc_hi_p1, acc_lo_p1, mcand_p1);
  end

  // ---- control and result register ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      cnt   <= '0;
      mdu_r <= '0;
    end else begin
      state <= state_n;
      if (flush || accept) begin
        cnt <= '0;
      end else if (state == BUSY) begin
        cnt <= cnt + CW'(1);
      end
      if (accept && quick_id) begin
        mdu_r <= quick_res_id;
      end else if ((state == BUSY) && last && !flush) begin
        mdu_r <= finish_res(func_p1, neg_p1, step_acc);
      end
    end
  end

  // ---- iteration datapath (stage p1) ----
  always_ff @(posedge clk) begin
    if (accept) begin
      func_p1   <= id_func;
      // REM follows the dividend sign; everything else is the sign xor.
      neg_p1    <= (is_div_id && id_func[1]) ? a_neg_id : (a_neg_id ^ b_neg_id);
      mcand_p1  <= is_div_id ? b_mag_id : a_mag_id;
      acc_hi_p1 <= '0;
      acc_lo_p1 <= is_div_id ? a_mag_id : b_mag_id;
    end else if (state == BUSY) begin
      {acc_hi_p1, acc_lo_p1} <= step_acc;
    end
  end

endmodule

// File: tb/tb_riscv_mdu.sv
// tb_riscv_mdu -- directed bench for riscv_mdu with BITS_PER_CYCLE 1 and 4.
// Inputs are driven and outputs sampled on the falling edge; cycle 0 is the
// cycle in which an operation is presented and accepted.
module tb_riscv_mdu;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  logic        clk = 1'b0;
  logic        rstn;
  logic        flush;
  logic        wb_stall;
  logic        id_bubble;
  logic        id_bubble4;
  logic        id_mdu_op;
  logic [2:0]  id_func;
  logic [31:0] opA, opB;
  logic [31:0] r1, r4;
  logic        bub1, bub4, stall1, stall4;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  riscv_mdu #(.XLEN(32), .BITS_PER_CYCLE(1)) dut (
    .clk(clk), .rstn(rstn), .flush(flush), .wb_stall(wb_stall),
    .id_bubble(id_bubble), .id_mdu_op(id_mdu_op), .id_func(id_func),
    .opA(opA), .opB(opB),
    .mdu_r(r1), .mdu_bubble(bub1), .mdu_stall(stall1)
  );

  riscv_mdu #(.XLEN(32), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rstn(rstn), .flush(flush), .wb_stall(wb_stall),
    .id_bubble(id_bubble4), .id_mdu_op(id_mdu_op), .id_func(id_func),
    .opA(opA), .opB(opB),
    .mdu_r(r4), .mdu_bubble(bub4), .mdu_stall(stall4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for DONE after an accept in the current cycle, checks
  // latency, result, stall behaviour, then the return to IDLE.
  task automatic finish_op(input string tag, input bit sel4, input int lat,
                           input logic [31:0] exp);
    int cyc;
    int bad_stall;
    @(negedge clk);
    id_mdu_op  = 1'b0;
    id_bubble  = 1'b1;
    id_bubble4 = 1'b1;
    opA        = $urandom;
    opB        = $urandom;
    id_func    = 3'($urandom);
    cyc        = 1;
    bad_stall  = 0;
    while ((sel4 ? bub4 : bub1) && cyc < 100) begin
      if (!(sel4 ? stall4 : stall1)) bad_stall++;
      @(negedge clk);
      opA = $urandom;
      opB = $urandom;
      cyc++;
    end
    chk({tag, "_latency"}, 64'(cyc), 64'(lat));
    chk({tag, "_result"}, sel4 ? r4 : r1, exp);
    chk({tag, "_stall_busy"}, 64'(bad_stall), 0);
    chk({tag, "_stall_done"}, sel4 ? stall4 : stall1, 0);
    @(negedge clk);
    chk({tag, "_idle_bubble"}, sel4 ? bub4 : bub1, 1);
    chk({tag, "_r_hold"}, sel4 ? r4 : r1, exp);
  endtask

  task automatic run_op(input string tag, input bit sel4, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] b,
                        input int lat, input logic [31:0] exp);
    id_func    = f;
    opA        = a;
    opB        = b;
    id_mdu_op  = 1'b1;
    id_bubble  = sel4;
    id_bubble4 = !sel4;
    #1;
    chk({tag, "_accept_stall"}, sel4 ? stall4 : stall1, 1);
    finish_op(tag, sel4, lat, exp);
  endtask

  initial begin
    int bad;
    rstn       = 1'b0;
    flush      = 1'b0;
    wb_stall   = 1'b0;
    id_bubble  = 1'b0;
    id_bubble4 = 1'b0;
    id_mdu_op  = 1'b1;
    id_func    = F_MUL;
    opA        = 32'd7;
    opB        = 32'd3;

    // Reset: offered op must not raise stall
    repeat (2) @(negedge clk);
    #1;
    chk("rst_r", r1, 0);
    chk("rst_bubble", bub1, 1);
    chk("rst_stall", stall1, 0);
    chk("rst_r4", r4, 0);
    chk("rst_stall4", stall4, 0);
    id_mdu_op  = 1'b0;
    id_bubble  = 1'b1;
    id_bubble4 = 1'b1;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Multiplies
    run_op("mul_7x-3", 0, F_MUL, 32'd7, 32'hFFFF_FFFD, 33, 32'hFFFF_FFEB);
    run_op("mulh_min2", 0, F_MULH, 32'h8000_0000, 32'h8000_0000, 33, 32'h4000_0000);
    run_op("mulh_min2_b4", 1, F_MULH, 32'h8000_0000, 32'h8000_0000, 9, 32'h4000_0000);
    run_op("mulhu_ff_b4", 1, F_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 9, 32'hFFFF_FFFE);
    run_op("mulhsu_b4", 1, F_MULHSU, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 9, 32'hFFFF_FFFE);

    // Divide by zero and signed overflow
    run_op("div_by0", 0, F_DIV, 32'd5, 32'd0, 1, 32'hFFFF_FFFF);
    run_op("remu_by0", 0, F_REMU, 32'd5, 32'd0, 1, 32'd5);
    run_op("div_ovf", 0, F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000);
    run_op("rem_ovf", 0, F_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0);
    run_op("rem_by0_b4", 1, F_REM, 32'hFFFF_FFF9, 32'd0, 1, 32'hFFFF_FFF9);

    // Signed division rounding
    run_op("rem_-7_2", 0, F_REM, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF);
    run_op("div_-7_2", 0, F_DIV, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD);
    run_op("div_7_-2_b4", 1, F_DIV, 32'd7, 32'hFFFF_FFFE, 9, 32'hFFFF_FFFD);
    run_op("remu_100_7_b4", 1, F_REMU, 32'd100, 32'd7, 9, 32'd2);

    // wb_stall hold, no re-accept of the held ID instruction, back-to-back op
    id_func   = F_MUL;
    opA       = 32'h0001_2345;
    opB       = 32'h0000_0010;
    id_mdu_op = 1'b1;
    id_bubble = 1'b0;
    #1;
    chk("wb_accept_stall", stall1, 1);
    for (int c = 1; c <= 37; c++) begin
      @(negedge clk);
      wb_stall = (c >= 33 && c <= 36);
      #1;
      if (c >= 33) begin
        chk($sformatf("wb_hold_bubble_c%0d", c), bub1, 0);
        chk($sformatf("wb_hold_r_c%0d", c), r1, 32'h0012_3450);
        chk($sformatf("wb_hold_stall_c%0d", c), stall1, 0);
      end
    end
    @(negedge clk);
    wb_stall = 1'b0;
    id_func  = F_DIVU;
    opA      = 32'd100;
    opB      = 32'd7;
    #1;
    chk("wb_idle_c38", bub1, 1);
    chk("b2b_accept_stall", stall1, 1);
    finish_op("divu_100_7", 0, 33, 32'd14);

    // Flush in the middle of a DIV
    id_func   = F_DIV;
    opA       = 32'hFFFF_FF9C;
    opB       = 32'd7;
    id_mdu_op = 1'b1;
    id_bubble = 1'b0;
    #1;
    chk("flush_accept_stall", stall1, 1);
    @(negedge clk);
    id_mdu_op = 1'b0;
    id_bubble = 1'b1;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    #1;
    chk("flush_c10_stall", stall1, 0);
    chk("flush_c10_bubble", bub1, 1);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush_c11_bubble", bub1, 1);
    chk("flush_c11_stall", stall1, 0);
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (!bub1 || stall1) bad++;
    end
    chk("flush_no_result", 64'(bad), 0);
    chk("flush_r_kept", r1, 32'd14);
    run_op("mul_after_flush", 0, F_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'd1);

    // Reset in the middle of an operation
    id_func   = F_MUL;
    opA       = 32'd3;
    opB       = 32'd5;
    id_mdu_op = 1'b1;
    id_bubble = 1'b0;
    @(negedge clk);
    id_mdu_op = 1'b0;
    id_bubble = 1'b1;
    repeat (5) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("midrst_r", r1, 0);
    chk("midrst_bubble", bub1, 1);
    chk("midrst_stall", stall1, 0);
    @(negedge clk);
    rstn = 1'b1;
    bad  = 0;
    repeat (40) begin
      @(negedge clk);
      if (!bub1 || stall1) bad++;
    end
    chk("midrst_stays_idle", 64'(bad), 0);
    run_op("mul_after_rst", 0, F_MUL, 32'd3, 32'd5, 33, 32'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
